rom_port_arbiter: RTL and testbench



---
 rtl/rom_port_arbiter_if.sv | 20 ++
 rtl/rom_port_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if
//   Toggle-handshake SDRAM port bundle. A request is outstanding while
//   mem_req != mem_ack; the slave copies mem_req onto mem_ack and presents
//   mem_q on the same edge to complete it.
//   master : arbiter side (drives req/a/ds/we/d, samples ack/q)
//   slave  : SDRAM controller side
interface rom_port_arbiter_if #(parameter int AW = 23);
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_a;
  logic [1:0]    mem_ds;
  logic          mem_we;
  logic [15:0]   mem_d;
  logic [15:0]   mem_q;

  modport master (output mem_req, mem_a, mem_ds, mem_we, mem_d,
                  input  mem_ack, mem_q);
  modport slave  (input  mem_req, mem_a, mem_ds, mem_we, mem_d,
                  output mem_ack, mem_q);
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one toggle-handshake SDRAM port between the ROM download writer
//   and two CPU ROM fetchers. Download bytes become byte-masked word writes;
//   CPU byte fetches are served from a one-word register per CPU, refilled
//   by a word read on a miss.
//
//   Ports:
//     clk_sys, reset           clock, async active-high reset
//     dl_active/wr/addr/data   download byte stream (rising dl_wr = 1 byte)
//     dl_overflow              sticky: a byte was dropped
//     cpuN_cs/addr             CPU fetch request / byte address
//     cpuN_q/valid             fetched byte, valid for the current address
//     sd                       SDRAM port (rom_port_arbiter_if.master)
//
//   Build option: ROM_ARB_CACHE_EN keeps word tags across cs deassertion so
//   a re-fetch of the same word hits without an SDRAM access. Without it
//   each new cs assertion forces a fresh read.
//
//   AW must be <= 24 so the word address fits in dl_addr[AW:1].
module rom_port_arbiter #(
  parameter int            AW        = 23,
  parameter logic [AW-1:0] CPU1_BASE = 'h000000,
  parameter logic [AW-1:0] CPU2_BASE = 'h008000
)(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_overflow,
  input  logic        cpu1_cs,
  input  logic        cpu2_cs,
  input  logic [15:0] cpu1_addr,
  input  logic [15:0] cpu2_addr,
  output logic [7:0]  cpu1_q,
  output logic [7:0]  cpu2_q,
  output logic        cpu1_valid,
  output logic        cpu2_valid,
  rom_port_arbiter_if.master sd
);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_BUSY} state_t;

  state_t r_state, w_state_nxt;

  // SDRAM port registers
  logic          r_req, r_we;
  logic [AW-1:0] r_a;
  logic [1:0]    r_ds;
  logic [15:0]   r_d;

  // job in flight
  logic          r_job_wr;
  logic          r_job_cpu;
  logic [14:0]   r_job_tag;
  logic          r_last;        // CPU index served last (loses a tie)

  // download buffer
  logic          r_dl_wr_d, r_dl_full, r_ovf;
  logic [24:0]   r_dl_addr;
  logic [7:0]    r_dl_data;

  // per-CPU state, index 0 = CPU1, 1 = CPU2
  logic [1:0]          w_cs, w_hit, w_miss;
  logic [1:0][15:0]    w_addr;
  logic [1:0][AW-1:0]  w_rd_a;
  logic [1:0]          r_tv, r_vld;
  logic [1:0][14:0]    r_tag;
  logic [1:0][15:0]    r_word;
  logic [1:0][7:0]     r_q;

  logic w_acked, w_dl_edge, w_issue, w_done, w_sel_wr, w_sel_cpu;
  logic w_unused_dl;

  assign w_cs      = {cpu2_cs, cpu1_cs};
  assign w_addr    = {cpu2_addr, cpu1_addr};
  assign w_rd_a[0] = CPU1_BASE + AW'(cpu1_addr[15:1]);
  assign w_rd_a[1] = CPU2_BASE + AW'(cpu2_addr[15:1]);

  assign w_acked     = (sd.mem_ack == r_req);
  assign w_dl_edge   = dl_wr & ~r_dl_wr_d;
  assign w_unused_dl = ^dl_addr;

  assign sd.mem_req  = r_req;
  assign sd.mem_a    = r_a;
  assign sd.mem_ds   = r_ds;
  assign sd.mem_we   = r_we;
  assign sd.mem_d    = r_d;

  assign dl_overflow = r_ovf;
  assign cpu1_q      = r_q[0];
  assign cpu2_q      = r_q[1];
  assign cpu1_valid  = r_vld[0];
  assign cpu2_valid  = r_vld[1];

  always_comb begin
    w_hit  = '0;
    w_miss = '0;
    for (int i = 0; i < 2; i++) begin
      w_hit[i]  = w_cs[i] & r_tv[i] & (r_tag[i] == w_addr[i][15:1]);
      w_miss[i] = w_cs[i] & ~w_hit[i] & ~dl_active;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) r_state <= S_SYNC;
    else       r_state <= w_state_nxt;

  // ---------------- FSM: next state ----------------
  // SYNC waits out an ack that was still in flight when reset hit, so a
  // stale completion is never mistaken for a new job's.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC:  if (w_acked) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_acked) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // ---------------- FSM: outputs (job select / completion) ----------------
  always_comb begin
    w_issue   = 1'b0;
    w_done    = 1'b0;
    w_sel_wr  = 1'b0;
    w_sel_cpu = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_dl_full) begin
          w_issue  = 1'b1;
          w_sel_wr = 1'b1;
        end else if (|w_miss) begin
          w_issue   = 1'b1;
          w_sel_cpu = (&w_miss) ? ~r_last : w_miss[1];
        end
      end
      S_BUSY:  w_done = w_acked;
      default: ;
    endcase
  end

  // ---------------- SDRAM port ----------------
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_req     <= 1'b0;
      r_a       <= '0;
      r_ds      <= 2'b00;
      r_we      <= 1'b0;
      r_d       <= '0;
      r_job_wr  <= 1'b0;
      r_job_cpu <= 1'b0;
      r_job_tag <= '0;
      r_last    <= 1'b0;
    end else if (w_issue) begin
      r_req    <= ~r_req;
      r_job_wr <= w_sel_wr;
      if (w_sel_wr) begin
        r_a  <= r_dl_addr[AW:1];
        r_ds <= {r_dl_addr[0], ~r_dl_addr[0]};
        r_we <= 1'b1;
        r_d  <= {r_dl_data, r_dl_data};
      end else begin
        r_a       <= w_rd_a[w_sel_cpu];
        r_ds      <= 2'b11;
        r_we      <= 1'b0;
        r_job_cpu <= w_sel_cpu;
        r_job_tag <= w_addr[w_sel_cpu][15:1];
        r_last    <= w_sel_cpu;
      end
    end

  // ---------------- download buffer ----------------
  // The buffer stays occupied until its write completes. A completion on
  // the same edge as a new strobe frees the slot first, so that byte fits.
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_dl_wr_d <= 1'b0;
      r_dl_full <= 1'b0;
      r_ovf     <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= '0;
    end else begin
      r_dl_wr_d <= dl_wr;
      if (w_dl_edge) begin
        if (!r_dl_full || (w_done && r_job_wr)) begin
          r_dl_full <= 1'b1;
          r_dl_addr <= dl_addr;
          r_dl_data <= dl_data;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_done && r_job_wr) begin
        r_dl_full <= 1'b0;
      end
    end

  // ---------------- per-CPU word registers ----------------
  // The tag written is the address issued, not the current one, so a CPU
  // that moved during the read simply misses and is re-requested.
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_tv   <= '0;
      r_tag  <= '0;
      r_word <= '0;
      r_vld  <= '0;
      r_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_vld[i] <= w_hit[i] & ~dl_active;
        r_q[i]   <= w_addr[i][0] ? r_word[i][15:8] : r_word[i][7:0];
        if (w_done && !r_job_wr && (int'(r_job_cpu) == i)) begin
          r_word[i] <= sd.mem_q;
          r_tag[i]  <= r_job_tag;
          r_tv[i]   <= 1'b1;
        end
        // freshly written ROM invalidates whatever was fetched before
        if (w_done && r_job_wr) r_tv[i] <= 1'b0;
`ifdef ROM_ARB_CACHE_EN
`else
        if (!w_cs[i]) r_tv[i] <= 1'b0;
`endif
      end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;
  localparam int AW = 23;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        dl_active = 1'b0, dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_overflow;
  logic        cpu1_cs = 1'b0, cpu2_cs = 1'b0;
  logic [15:0] cpu1_addr = '0, cpu2_addr = '0;
  logic [7:0]  cpu1_q, cpu2_q;
  logic        cpu1_valid, cpu2_valid;

  int total = 0;
  int bad   = 0;

  rom_port_arbiter_if #(.AW(AW)) bus();

  rom_port_arbiter #(.AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_overflow(dl_overflow),
    .cpu1_cs(cpu1_cs), .cpu2_cs(cpu2_cs), .cpu1_addr(cpu1_addr), .cpu2_addr(cpu2_addr),
    .cpu1_q(cpu1_q), .cpu2_q(cpu2_q), .cpu1_valid(cpu1_valid), .cpu2_valid(cpu2_valid),
    .sd(bus)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acks sd_lat edges after a toggle, logs each new request
  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
  } txn_t;

  txn_t        log_q[$];
  int          sd_lat = 3;
  int          sd_cnt = 0;
  logic        sd_fix = 1'b0;
  logic [15:0] sd_fixed = '0;
  logic        sd_ack = 1'b0;
  logic [15:0] sd_q = '0;
  logic        seen_req = 1'b0;

  assign bus.mem_ack = sd_ack;
  assign bus.mem_q   = sd_q;

  always @(posedge clk_sys) begin
    seen_req <= bus.mem_req;
    if (bus.mem_req != seen_req)
      log_q.push_back(txn_t'({bus.mem_we, bus.mem_a, bus.mem_ds, bus.mem_d}));
    if (bus.mem_req != sd_ack) begin
      if (sd_cnt >= sd_lat - 1) begin
        sd_ack <= bus.mem_req;
        sd_q   <= sd_fix ? sd_fixed : (bus.mem_a[15:0] ^ 16'hA5A5);
        sd_cnt <= 0;
      end else begin
        sd_cnt <= sd_cnt + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_req == bus.mem_ack) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_req != bus.mem_ack) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_v1(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (cpu1_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_v2(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (cpu2_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (log_q.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    logic [43:0] outs;
    tick(); tick();
    outs = {bus.mem_req, bus.mem_a, bus.mem_ds, bus.mem_we, bus.mem_d};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_mem got=%h want=0", outs); end
    total++;
    if ({cpu1_q, cpu2_q, cpu1_valid, cpu2_valid, dl_overflow} !== 19'd0) begin
      bad++; $display("FAIL reset_cpu got=%h want=0", {cpu1_q, cpu2_q, cpu1_valid, cpu2_valid, dl_overflow});
    end
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_download;
    bit ok; int n0; txn_t t0, t1;
    dl_active = 1'b1; sd_lat = 3; n0 = log_q.size();
    dl_addr = 25'h0; dl_data = 8'h12; dl_wr = 1'b1; tick();
    dl_wr = 1'b0; tick();
    wait_ack(ok);
    total++; if (!ok) begin bad++; $display("FAIL dl_ack1 timeout got=0 want=1"); end
    // next edge completes byte 1 and sees the strobe for byte 2
    dl_addr = 25'h1; dl_data = 8'h34; dl_wr = 1'b1; tick();
    dl_wr = 1'b0; tick();
    wait_ack(ok); tick(); tick();
    total++;
    if (log_q.size() != n0 + 2) begin
      bad++; $display("FAIL dl_count got=%0d want=%0d", log_q.size() - n0, 2);
    end else begin
      t0 = log_q[n0]; t1 = log_q[n0 + 1];
      total++;
      if (t0 !== txn_t'({1'b1, 23'h0, 2'b01, 16'h1212})) begin
        bad++; $display("FAIL dl_wr1 got=%h want=%h", t0, txn_t'({1'b1, 23'h0, 2'b01, 16'h1212}));
      end
      total++;
      if (t1 !== txn_t'({1'b1, 23'h0, 2'b10, 16'h3434})) begin
        bad++; $display("FAIL dl_wr2 got=%h want=%h", t1, txn_t'({1'b1, 23'h0, 2'b10, 16'h3434}));
      end
    end
    total++;
    if (dl_overflow !== 1'b0) begin bad++; $display("FAIL dl_no_ovf got=%b want=0", dl_overflow); end
    dl_active = 1'b0;
  endtask

  task automatic test_cpu_read;
    bit ok; int n0; txn_t t;
    sd_lat = 5; sd_fix = 1'b1; sd_fixed = 16'hBEEF; n0 = log_q.size();
    cpu1_addr = 16'h0003; cpu1_cs = 1'b1;
    wait_log(n0 + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rd_issue timeout got=0 want=1"); end
    else begin
      t = log_q[n0];
    end
    if (ok) begin
      total++;
      if ({t.we, t.a, t.ds} !== {1'b0, 23'h000001, 2'b11}) begin
        bad++; $display("FAIL rd_req got=%h want=%h", {t.we, t.a, t.ds}, {1'b0, 23'h000001, 2'b11});
      end
    end
    wait_ack(ok);
    tick();
    total++;
    if (cpu1_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_early got=%b want=0", cpu1_valid); end
    tick();
    total++;
    if ({cpu1_valid, cpu1_q} !== {1'b1, 8'hBE}) begin
      bad++; $display("FAIL rd_data got=%b/%h want=1/be", cpu1_valid, cpu1_q);
    end
    sd_fix = 1'b0;
  endtask

  task automatic test_round_robin;
    bit ok1, ok2; int n0;
    sd_lat = 2; n0 = log_q.size();
    // CPU1 was served last, so CPU2 wins the tie
    cpu1_addr = 16'h0042; cpu2_addr = 16'h0010; cpu2_cs = 1'b1;
    wait_v2(ok2);
    wait_v1(ok1);
    total++;
    if (!(ok1 && ok2)) begin bad++; $display("FAIL rr_valid got=%b%b want=11", ok1, ok2); end
    total++;
    if (log_q.size() != n0 + 2) begin
      bad++; $display("FAIL rr_count got=%0d want=2", log_q.size() - n0);
    end else begin
      total++;
      if (log_q[n0].a !== 23'h008008) begin bad++; $display("FAIL rr_first got=%h want=008008", log_q[n0].a); end
      total++;
      if (log_q[n0 + 1].a !== 23'h000021) begin bad++; $display("FAIL rr_second got=%h want=000021", log_q[n0 + 1].a); end
    end
    total++;
    if ({cpu2_q, cpu1_q} !== {8'hAD, 8'h84}) begin
      bad++; $display("FAIL rr_data got=%h%h want=ad84", cpu2_q, cpu1_q);
    end
    cpu2_cs = 1'b0;
    tick();
  endtask

  task automatic test_cache;
    int n0;
    cpu1_cs = 1'b0; tick(); tick();
    cpu1_cs = 1'b1; n0 = log_q.size();
    tick();
`ifdef ROM_ARB_CACHE_EN
    total++;
    if ({cpu1_valid, cpu1_q} !== {1'b1, 8'h84}) begin
      bad++; $display("FAIL cache_hit got=%b/%h want=1/84", cpu1_valid, cpu1_q);
    end
    tick(); tick();
    total++;
    if (log_q.size() != n0) begin bad++; $display("FAIL cache_noreq got=%0d want=0", log_q.size() - n0); end
`else
    begin
      bit ok;
      total++;
      if (cpu1_valid !== 1'b0) begin bad++; $display("FAIL nocache_miss got=%b want=0", cpu1_valid); end
      wait_v1(ok);
      total++;
      if (!ok || log_q.size() != n0 + 1 || cpu1_q !== 8'h84) begin
        bad++; $display("FAIL nocache_refetch got=%0d/%h want=1/84", log_q.size() - n0, cpu1_q);
      end
    end
`endif
  endtask

  task automatic test_dl_active;
    bit ok; int n0;
    dl_active = 1'b1; n0 = log_q.size();
    tick();
    total++;
    if (cpu1_valid !== 1'b0) begin bad++; $display("FAIL dla_valid got=%b want=0", cpu1_valid); end
    cpu1_addr = 16'h0050;
    tick(); tick(); tick(); tick();
    total++;
    if (log_q.size() != n0) begin bad++; $display("FAIL dla_noreq got=%0d want=0", log_q.size() - n0); end
    dl_active = 1'b0;
    wait_v1(ok);
    total++;
    if (!ok || cpu1_q !== 8'h8D) begin bad++; $display("FAIL dla_resume got=%b/%h want=1/8d", ok, cpu1_q); end
    cpu1_cs = 1'b0;
    tick();
  endtask

  task automatic test_overflow;
    bit ok; int n0;
    dl_active = 1'b1; sd_lat = 8; n0 = log_q.size();
    dl_addr = 25'h10; dl_data = 8'h55; dl_wr = 1'b1; tick();
    dl_wr = 1'b0; tick();
    total++;
    if (dl_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b want=0", dl_overflow); end
    dl_addr = 25'h11; dl_data = 8'h66; dl_wr = 1'b1; tick();
    dl_wr = 1'b0; tick();
    dl_addr = 25'h12; dl_data = 8'h77; dl_wr = 1'b1; tick();
    dl_wr = 1'b0; tick();
    wait_ack(ok);
    tick(); tick(); tick(); tick();
    total++;
    if (dl_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", dl_overflow); end
    total++;
    if (log_q.size() != n0 + 1) begin
      bad++; $display("FAIL ovf_count got=%0d want=1", log_q.size() - n0);
    end else begin
      total++;
      if (log_q[n0] !== txn_t'({1'b1, 23'h8, 2'b01, 16'h5555})) begin
        bad++; $display("FAIL ovf_wr got=%h want=%h", log_q[n0], txn_t'({1'b1, 23'h8, 2'b01, 16'h5555}));
      end
    end
    dl_active = 1'b0;
  endtask

  task automatic test_reset_midflight;
    bit ok, quiet, still_inv; int n0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    wait_ack(ok);
    sd_lat = 2; cpu1_addr = 16'h0010; cpu1_cs = 1'b1;
    wait_v1(ok);
    sd_lat = 6; sd_fix = 1'b1; sd_fixed = 16'hDEAD;
    cpu1_addr = 16'h0020;
    wait_busy(ok);
    tick(); tick();
    reset = 1'b1; #1;
    total++;
    if ({bus.mem_req, bus.mem_a, bus.mem_ds, bus.mem_we, bus.mem_d} !== 44'd0) begin
      bad++; $display("FAIL rst_mid_outs got=%h want=0", {bus.mem_req, bus.mem_a, bus.mem_ds, bus.mem_we, bus.mem_d});
    end
    total++;
    if ({dl_overflow, cpu1_valid, cpu1_q} !== 10'd0) begin
      bad++; $display("FAIL rst_mid_flags got=%h want=0", {dl_overflow, cpu1_valid, cpu1_q});
    end
    tick(); reset = 1'b0;
    n0 = log_q.size(); quiet = 1'b1; still_inv = 1'b1; ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (log_q.size() != n0) quiet = 1'b0;
      if (cpu1_valid) still_inv = 1'b0;
      if (bus.mem_req == bus.mem_ack) begin ok = 1'b1; break; end
    end
    total++;
    if (!(ok && quiet && still_inv)) begin
      bad++; $display("FAIL rst_sync got=%b%b%b want=111", ok, quiet, still_inv);
    end
    sd_fixed = 16'h5A3C;
    wait_v1(ok);
    total++;
    if (!ok || log_q.size() != n0 + 1 || cpu1_q !== 8'h3C) begin
      bad++; $display("FAIL rst_resume got=%0d/%h want=1/3c", log_q.size() - n0, cpu1_q);
    end else begin
      total++;
      if (log_q[n0].a !== 23'h000010) begin bad++; $display("FAIL rst_resume_a got=%h want=000010", log_q[n0].a); end
    end
    cpu1_cs = 1'b0; sd_fix = 1'b0;
  endtask

  initial begin
    test_reset();
    test_download();
    test_cpu_read();
    test_round_robin();
    test_cache();
    test_dl_active();
    test_overflow();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
